reg_wr_arb: RTL and testbench
=============================

Name: reg_wr_arb

Overview:
Round-robin arbiter that shares one register-bank write port among REQ_NUM requesters, such as ALU, LSU and CSR writeback sources.
- Each requester offers addr/data with a valid/ready handshake.
- One request is granted per cycle and placed in a registered output slot.
- The slot is held until the register bank accepts it.
- Sits between the writeback sources and the register file write port.

Parameters:
REQ_NUM, 4, number of requesters (2..8)
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, write data width
ID_WIDTH, $clog2(REQ_NUM), width of grant id

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_req_valid  in  REQ_NUM  per-requester request valid
o_req_ready  out  REQ_NUM  per-requester accept (one-hot or zero)
i_req_addr  in  REQ_NUM*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_req_data  in  REQ_NUM*DATA_WIDTH  packed data, same packing
o_wr_en  out  1  output slot valid
o_wr_addr  out  ADDR_WIDTH  write address
o_wr_data  out  DATA_WIDTH  write data
o_wr_id  out  ID_WIDTH  index of the requester that owns the slot
i_wr_ready  in  1  register bank accepts the slot this cycle

Behaviour:
- Reset (async assert, sync release): o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_wr_id=0, rr pointer=0. o_req_ready=0 while i_rst_n=0.
- Slot states: EMPTY (o_wr_en=0), FULL (o_wr_en=1).
- can_load = !o_wr_en || i_wr_ready. This gives full throughput: drain and load in the same cycle.
- Pick: first k with i_req_valid[k]=1, scanning from ptr upward modulo REQ_NUM.
- o_req_ready = onehot(pick) when can_load and any valid, else 0. This is combinational from i_req_valid, ptr, o_wr_en and i_wr_ready.
- Handshake on requester k: i_req_valid[k] && o_req_ready[k].
  - At the next clock edge the slot loads addr/data/id=k, o_wr_en=1, and ptr=(k+1) mod REQ_NUM.
  - Latency is 1 cycle from handshake to o_wr_en.
- FULL && !i_wr_ready: slot contents are frozen and o_req_ready=0.
- FULL && i_wr_ready && no valid requests: slot goes to EMPTY; addr/data/id keep their last values.
- Requesters may hold or drop valid freely while not granted; no fairness credit is kept.
- The ptr moves only on a handshake, never on idle cycles.
- REQ_NUM not a power of two: wrap is explicit modulo, and ids ≥ REQ_NUM never occur.
- Async reset mid-transfer discards the slot immediately. Any requester that had handshaken but not yet been written is lost, by design; the upstream flush covers it.

Optional Feature:
Macro REG_WR_ARB_ZERO_DROP_EN.
- Defined: a granted request with addr==0 still handshakes (o_req_ready pulses) and advances ptr, but does not load the slot. The slot behaves as if no request was granted, so o_wr_en never asserts with o_wr_addr==0. This models a hardwired zero register.
- Undefined: address 0 is treated like any other address.

Decomposition:
- Package reg_wr_arb_pkg:
  - typedef struct wr_req_t {addr, data}, parameterized through localparams ADDR_WIDTH/DATA_WIDTH.
  - function rr_next(ptr, k) for modulo increment.
- Sub-module rr_pick: combinational, REQ_NUM-wide rotate-priority picker. Inputs are valid and ptr; outputs are one-hot grant, index and any.
- Output slot and ptr: built from the team's async-reset, enable register primitive (enable = load / handshake).

Test Plan:
- Reset check: assert i_rst_n=0 with all valid=1 -> o_wr_en=0, o_req_ready=0, outputs 0. Release -> requester 0 granted first, o_wr_id=0 the next cycle.
- Round-robin fairness: all 4 valid continuously, i_wr_ready=1 -> o_wr_id sequence 0,1,2,3,0,… with o_wr_en=1 every cycle; each requester gets 1 grant per 4 cycles.
- Backpressure: requester 2 writes addr=7/data=0xDEADBEEF, i_wr_ready=0 for 3 cycles -> slot frozen at 7/0xDEADBEEF and o_req_ready=0 throughout. i_wr_ready=1 -> the next grant loads in the same cycle.
- Sparse requests with wrap: ptr=3, only requester 1 valid -> requester 1 granted, next ptr=2. Then requesters 0 and 3 valid -> 3 granted before 0.
- Async reset mid-operation: drop i_rst_n between clock edges while o_wr_en=1 -> o_wr_en goes to 0 without a clock edge, and ptr returns to 0.
- Zero-address handling, with REG_WR_ARB_ZERO_DROP_EN: requester 1 addr=0 then requester 2 addr=5 -> ready pulses for both, o_wr_en asserts only for addr 5. Without the macro, both writes appear in order.

Source files
------------

// File: rtl/reg_wr_arb_pkg.sv
// Shared types and helpers for the register-write arbiter.
package reg_wr_arb_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  // Round-robin successor of requester k, wrapping explicitly at req_num.
  function automatic int unsigned rr_next(input int unsigned k, input int unsigned req_num);
    return (k + 1 >= req_num) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/reg_wr_arb_rr_pick.sv
// Combinational rotate-priority picker: first valid requester at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned ID_WIDTH = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0]  valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [REQ_NUM-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Upper segment [ptr, REQ_NUM) has priority over the wrapped segment [0, ptr).
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      if (!any && valid[i] && (i >= int'(ptr))) begin
        any = 1'b1;
        idx = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      if (!any && valid[i]) begin
        any = 1'b1;
        idx = ID_WIDTH'(i);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_wr_arb.sv
// Round-robin arbiter sharing one register-bank write port through a registered output slot.
// Optional REG_WR_ARB_ZERO_DROP_EN: grants to address 0 handshake but never load the slot.
module reg_wr_arb #(
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = $clog2(REQ_NUM)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [REQ_NUM-1:0]            i_req_valid,
  output logic [REQ_NUM-1:0]            o_req_ready,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_data,
  output logic                          o_wr_en,
  output logic [ADDR_WIDTH-1:0]         o_wr_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [ID_WIDTH-1:0]           o_wr_id,
  input  logic                          i_wr_ready
);

  import reg_wr_arb_pkg::*;

  logic [REQ_NUM-1:0]    grant;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_data;

  logic [0:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ID_WIDTH-1:0]   id_q;

  logic can_load;
  logic handshake;
  logic load;

  rr_pick #(
    .REQ_NUM  (REQ_NUM),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .valid (i_req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    for (int k = 0; k < int'(REQ_NUM); k++) begin
      if (grant[k]) begin
        pick_addr = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        pick_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    can_load = (state_q == SLOT_EMPTY) || i_wr_ready;
    // Gated by reset so nothing is accepted while the slot is held cleared.
    o_req_ready = (i_rst_n && can_load && pick_any) ? grant : '0;
    handshake = |o_req_ready;
`ifdef REG_WR_ARB_ZERO_DROP_EN
    load = handshake && (pick_addr != '0);
`else
    load = handshake;
`endif
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SLOT_FULL;
    end else if (i_wr_ready) begin
      state_d = SLOT_EMPTY;
    end
    ptr_d = handshake ? ID_WIDTH'(rr_next(32'(pick_idx), REQ_NUM)) : ptr_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (load) begin
        addr_q <= pick_addr;
        data_q <= pick_data;
        id_q   <= pick_idx;
      end
    end
  end

  assign o_wr_en   = (state_q == SLOT_FULL);
  assign o_wr_addr = addr_q;
  assign o_wr_data = data_q;
  assign o_wr_id   = id_q;

endmodule

// File: tb/tb_reg_wr_arb.sv
// Scoreboard bench for reg_wr_arb: a queue-based reference model predicts grants and slot writes.
module tb_reg_wr_arb;

  import reg_wr_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;

`ifdef REG_WR_ARB_ZERO_DROP_EN
  localparam bit ZeroDrop = 1'b1;
`else
  localparam bit ZeroDrop = 1'b0;
`endif

  typedef struct packed {
    logic [IW-1:0] id;
    wr_req_t       req;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   wr_id;
  logic            wr_ready;

  exp_t exp_q[$];
  int   m_ptr;
  bit   m_full;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_wr_arb #(
    .REQ_NUM    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_wr_id     (wr_id),
    .i_wr_ready  (wr_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic rand_payload(output logic [N*AW-1:0] pa, output logic [N*DW-1:0] pd);
    for (int k = 0; k < N; k++) begin
      pa[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      pd[k*DW +: DW] = $urandom;
    end
  endtask

  // One cycle: drive inputs after the falling edge, predict, compare, then advance the model.
  task automatic step(input logic [N-1:0] v, input bit rdy,
                      input logic [N*AW-1:0] pa, input logic [N*DW-1:0] pd);
    int         pick;
    logic [N-1:0] exp_rdy;
    exp_t       e;
    @(negedge clk);
    valid    = v;
    wr_ready = rdy;
    req_addr = pa;
    req_data = pd;
    #1;
    pick = -1;
    if (!m_full || rdy) begin
      for (int i = 0; i < N; i++) begin
        if (pick < 0 && v[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
      end
    end
    exp_rdy = '0;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("wr_en", 64'(wr_en), 64'(m_full));
    if (pick >= 0) begin
      m_ptr = (pick + 1) % N;
      e.id       = IW'(pick);
      e.req.addr = pa[pick*AW +: AW];
      e.req.data = pd[pick*DW +: DW];
      if (ZeroDrop && e.req.addr == '0) begin
        if (rdy) m_full = 1'b0;
      end else begin
        exp_q.push_back(e);
        m_full = 1'b1;
      end
    end else if (rdy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_wr_id"}, 64'(wr_id), 64'd0);
  endtask

  // Monitor: the slot must always show the oldest outstanding predicted write.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL slot_expected actual=write id=%0d addr=%0h required=no write at %0t",
                 wr_id, wr_addr, $time);
      end else begin
        check("wr_id", 64'(wr_id), 64'(exp_q[0].id));
        check("wr_addr", 64'(wr_addr), 64'(exp_q[0].req.addr));
        check("wr_data", 64'(wr_data), 64'(exp_q[0].req.data));
        if (wr_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [N*AW-1:0] pa;
    logic [N*DW-1:0] pd;

    rst_n    = 1'b0;
    valid    = '1;
    wr_ready = 1'b0;
    req_addr = '0;
    req_data = '0;
    m_ptr    = 0;
    m_full   = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    valid = '0;
    rst_n = 1'b1;

    // All requesters continuously valid: grants rotate 0,1,2,3 with a write every cycle.
    for (int c = 0; c < 12; c++) begin
      rand_payload(pa, pd);
      step(4'b1111, 1'b1, pa, pd);
    end

    // Backpressure: requester 2's write is held for three cycles, then replaced in one cycle.
    rand_payload(pa, pd);
    pa[2*AW +: AW] = 5'd7;
    pd[2*DW +: DW] = 32'hDEAD_BEEF;
    step(4'b0100, 1'b1, pa, pd);
    for (int c = 0; c < 3; c++) begin
      rand_payload(pa, pd);
      step(4'b1111, 1'b0, pa, pd);
    end
    rand_payload(pa, pd);
    step(4'b1111, 1'b1, pa, pd);

    // Wrap: put ptr at 3, grant 1 (ptr->2), then 3 must win over 0.
    rand_payload(pa, pd);
    step(4'b0100, 1'b1, pa, pd);
    rand_payload(pa, pd);
    step(4'b0010, 1'b1, pa, pd);
    rand_payload(pa, pd);
    step(4'b1001, 1'b1, pa, pd);
    rand_payload(pa, pd);
    step(4'b1001, 1'b1, pa, pd);

    // Zero address from requester 1 followed by address 5 from requester 2.
    rand_payload(pa, pd);
    pa[1*AW +: AW] = 5'd0;
    step(4'b0010, 1'b1, pa, pd);
    rand_payload(pa, pd);
    pa[2*AW +: AW] = 5'd5;
    step(4'b0100, 1'b1, pa, pd);
    rand_payload(pa, pd);
    step(4'b0000, 1'b1, pa, pd);

    // Asynchronous reset between edges while the slot is full.
    rand_payload(pa, pd);
    step(4'b1000, 1'b0, pa, pd);
    @(negedge clk);
    #3;
    valid = '1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    @(negedge clk);
    valid = '0;
    rst_n = 1'b1;
    rand_payload(pa, pd);
    step(4'b1111, 1'b1, pa, pd);

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      rand_payload(pa, pd);
      step(N'($urandom), ($urandom_range(0, 9) < 7), pa, pd);
    end

    for (int c = 0; c < 3; c++) begin
      rand_payload(pa, pd);
      step(4'b0000, 1'b1, pa, pd);
    end
    #3;
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
